// File: rtl/config_word_sequencer.sv
// Shares the fabric config write port between the bitbang and loader word sources and turns
// each granted stream into {base,count} framed writes. Optional idle timeout: CFG_SEQ_TIMEOUT_EN.
module config_word_sequencer #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              bb_strobe,
    input  logic [31:0]       bb_data,
    input  logic              bb_active,
    input  logic              ld_strobe,
    input  logic [31:0]       ld_data,
    input  logic              ld_active,
    output logic              cfg_wr,
    output logic [ADDR_W-1:0] cfg_addr,
    output logic [31:0]       cfg_data,
    output logic              frame_done,
    output logic [1:0]        owner,
    output logic [7:0]        drop_cnt,
    output logic [2:0]        err_flags,
    input  logic              err_clr
);

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_BB   = 2'b01;
    localparam logic [1:0] OWN_LD   = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA} state_t;

    state_t            state, state_n;
    logic [1:0]        owner_n;
    logic [ADDR_W-1:0] base, base_n;
    logic [CNT_W-1:0]  rem, rem_n;
    logic [ADDR_W-1:0] idx, idx_n;
    logic              wr_n, done_n;
    logic [ADDR_W-1:0] addr_n;
    logic [31:0]       data_n;
    logic [7:0]        drop_n;
    logic [2:0]        err_n;

    logic              own_strobe, own_active, foreign_strobe;
    logic [31:0]       own_data;

`ifdef CFG_SEQ_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TO_W-1:0] tcnt, tcnt_n;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    // Next-state, arbitration and registered-output values
    always_comb begin
        state_n        = state;
        owner_n        = owner;
        base_n         = base;
        rem_n          = rem;
        idx_n          = idx;
        wr_n           = 1'b0;
        done_n         = 1'b0;
        addr_n         = cfg_addr;
        data_n         = cfg_data;
        drop_n         = err_clr ? 8'd0 : drop_cnt;
        err_n          = err_clr ? 3'd0 : err_flags;
        own_strobe     = 1'b0;
        own_active     = 1'b0;
        own_data       = '0;
        foreign_strobe = 1'b0;
`ifdef CFG_SEQ_TIMEOUT_EN
        tcnt_n         = tcnt;
`endif

        case (owner)
            OWN_BB: begin
                own_strobe     = bb_strobe;
                own_active     = bb_active;
                own_data       = bb_data;
                foreign_strobe = ld_strobe;
            end
            OWN_LD: begin
                own_strobe     = ld_strobe;
                own_active     = ld_active;
                own_data       = ld_data;
                foreign_strobe = bb_strobe;
            end
            default: ;
        endcase

        if (!err_clr && foreign_strobe && drop_cnt != 8'hFF) begin
            drop_n = drop_cnt + 8'd1;
        end

        case (state)
            S_IDLE: begin
                // Bitbang has priority when both sessions open together
                if (bb_active) begin
                    owner_n = OWN_BB;
                    state_n = S_HDR;
                end else if (ld_active) begin
                    owner_n = OWN_LD;
                    state_n = S_HDR;
                end
            end
            S_HDR, S_DATA: begin
                if (!own_active) begin
                    owner_n = OWN_NONE;
                    state_n = S_IDLE;
                    if (state == S_DATA) begin
                        err_n[1] = 1'b1;
                    end
                end else if (own_strobe) begin
`ifdef CFG_SEQ_TIMEOUT_EN
                    tcnt_n = '0;
`endif
                    if (state == S_HDR) begin
                        if (own_data[CNT_W-1:0] == '0) begin
                            err_n[0] = 1'b1;
                        end else begin
                            base_n  = own_data[31 -: ADDR_W];
                            rem_n   = own_data[CNT_W-1:0];
                            idx_n   = '0;
                            state_n = S_DATA;
                        end
                    end else begin
                        wr_n   = 1'b1;
                        data_n = own_data;
                        addr_n = base + idx;
                        idx_n  = idx + ADDR_W'(1);
                        rem_n  = rem - CNT_W'(1);
                        if (rem == CNT_W'(1)) begin
                            done_n  = 1'b1;
                            state_n = S_HDR;
                        end
                    end
                end
`ifdef CFG_SEQ_TIMEOUT_EN
                else if (state == S_DATA) begin
                    // Idle gap too long: drop the partial frame but keep the session
                    if (tcnt == TO_W'(TIMEOUT - 1)) begin
                        err_n[2] = 1'b1;
                        tcnt_n   = '0;
                        state_n  = S_HDR;
                    end else begin
                        tcnt_n = tcnt + TO_W'(1);
                    end
                end
`endif
            end
            default: begin
                owner_n = OWN_NONE;
                state_n = S_IDLE;
            end
        endcase

`ifndef CFG_SEQ_TIMEOUT_EN
        err_n[2] = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= S_IDLE;
            owner      <= OWN_NONE;
            base       <= '0;
            rem        <= '0;
            idx        <= '0;
            cfg_wr     <= 1'b0;
            cfg_addr   <= '0;
            cfg_data   <= '0;
            frame_done <= 1'b0;
            drop_cnt   <= 8'd0;
            err_flags  <= 3'd0;
`ifdef CFG_SEQ_TIMEOUT_EN
            tcnt       <= '0;
`endif
        end else begin
            state      <= state_n;
            owner      <= owner_n;
            base       <= base_n;
            rem        <= rem_n;
            idx        <= idx_n;
            cfg_wr     <= wr_n;
            cfg_addr   <= addr_n;
            cfg_data   <= data_n;
            frame_done <= done_n;
            drop_cnt   <= drop_n;
            err_flags  <= err_n;
`ifdef CFG_SEQ_TIMEOUT_EN
            tcnt       <= tcnt_n;
`endif
        end
    end

endmodule
